// File: rtl/controle_bloqueio_if.sv
// controle_bloqueio_if: keypad/verification/lock signal bundle for the access supervisor
interface controle_bloqueio_if;
  logic tecla_ativada;
  logic verif_fim;
  logic verif_ok;
  logic fechar;
  logic tecla_lib;
  logic trava_aberta;
  logic bloqueado;
  logic alarme;
  logic cfg_permitido;
  logic [1:0] tentativas;
  modport master (
    output tecla_ativada, verif_fim, verif_ok, fechar,
    input  tecla_lib, trava_aberta, bloqueado, alarme, cfg_permitido, tentativas
  );
  modport slave (
    input  tecla_ativada, verif_fim, verif_ok, fechar,
    output tecla_lib, trava_aberta, bloqueado, alarme, cfg_permitido, tentativas
  );
endinterface

// File: rtl/controle_bloqueio.sv
// controle_bloqueio: timed lock opening, failure counting and lockout supervisor
module controle_bloqueio #(
  parameter int T_ABERTO       = 8,
  parameter int T_BLOQUEIO     = 32,
  parameter int MAX_TENTATIVAS = 3,
  parameter int TW             = 16
) (
  input  logic clk,
  input  logic reset_n,
  controle_bloqueio_if.slave bus
);
  typedef enum logic [1:0] {OCIOSO, ABERTO, BLOQUEIO} estado_t;
  localparam logic [TW-1:0] TA = TW'(T_ABERTO - 1);
  localparam logic [TW-1:0] TB = TW'(T_BLOQUEIO - 1);
  localparam logic [1:0]    MX = 2'(MAX_TENTATIVAS);
  estado_t estado, prox;
  logic [TW-1:0] timer, timer_n;
  logic [1:0] tent, tent_n;
  logic alarme, alarme_n;
  wire sucesso = bus.verif_fim & bus.verif_ok;
  wire falha   = bus.verif_fim & ~bus.verif_ok;
  // next state, shared timer and failure count
  always_comb begin
    prox     = estado;
    timer_n  = timer;
    tent_n   = tent;
    alarme_n = 1'b0;
    case (estado)
      OCIOSO:
        if (sucesso) begin
          prox    = ABERTO;
          timer_n = TA;
          tent_n  = 2'd0;
        end else if (falha) begin
          if (tent + 2'd1 == MX) begin
            prox     = BLOQUEIO;
            timer_n  = TB;
            tent_n   = MX;
            alarme_n = 1'b1;
          end else tent_n = tent + 2'd1;
        end
      ABERTO:
        if (bus.fechar) begin
          prox    = OCIOSO;
          timer_n = '0;
        end else if (sucesso) timer_n = TA;
        else if (timer == '0) prox = OCIOSO;
        else timer_n = timer - TW'(1);
      BLOQUEIO:
        if (timer == '0) begin
          prox   = OCIOSO;
          tent_n = 2'd0;
        end else timer_n = timer - TW'(1);
      default: begin
        prox    = OCIOSO;
        timer_n = '0;
        tent_n  = 2'd0;
      end
    endcase
  end
  // state, timer, counter and alarm pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado <= OCIOSO;
      timer  <= '0;
      tent   <= 2'd0;
      alarme <= 1'b0;
    end else begin
      estado <= prox;
      timer  <= timer_n;
      tent   <= tent_n;
      alarme <= alarme_n;
    end
  end
  assign bus.trava_aberta  = estado == ABERTO;
  assign bus.cfg_permitido = estado == ABERTO;
  assign bus.bloqueado     = estado == BLOQUEIO;
  assign bus.alarme        = alarme;
  assign bus.tentativas    = tent;
  assign bus.tecla_lib     = bus.tecla_ativada & reset_n & (estado != BLOQUEIO);
endmodule

// File: tb/tb_controle_bloqueio.sv
// tb_controle_bloqueio: directed stimulus with a remaining-cycles model checked every cycle
module tb_controle_bloqueio;
  logic clk = 1'b0;
  logic reset_n;
  logic tecla = 1'b0, fim = 1'b0, ok = 1'b0, fec = 1'b0;
  int n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  controle_bloqueio_if ia ();
  controle_bloqueio_if ib ();
  assign ia.tecla_ativada = tecla;
  assign ia.verif_fim     = fim;
  assign ia.verif_ok      = ok;
  assign ia.fechar        = fec;
  assign ib.tecla_ativada = tecla;
  assign ib.verif_fim     = fim;
  assign ib.verif_ok      = ok;
  assign ib.fechar        = fec;
  controle_bloqueio dut_a (.clk(clk), .reset_n(reset_n), .bus(ia.slave));
  controle_bloqueio #(.T_ABERTO(1), .T_BLOQUEIO(4), .MAX_TENTATIVAS(1), .TW(16))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(ib.slave));
  typedef struct packed {
    int   open_left;
    int   lock_left;
    int   fails;
    logic alarm;
  } model_t;
  model_t ma = '0, mb = '0;
  function automatic model_t step(model_t m, int ta, int tbl, int mx, logic f, logic k, logic fc);
    model_t r;
    r = m;
    r.alarm = 1'b0;
    if (m.lock_left > 0) begin
      r.lock_left = m.lock_left - 1;
      if (r.lock_left == 0) r.fails = 0;
    end else if (m.open_left > 0) begin
      if (fc) r.open_left = 0;
      else if (f && k) r.open_left = ta;
      else r.open_left = m.open_left - 1;
    end else if (f && k) begin
      r.open_left = ta;
      r.fails = 0;
    end else if (f) begin
      if (m.fails + 1 < mx) r.fails = m.fails + 1;
      else begin
        r.lock_left = tbl;
        r.fails = mx;
        r.alarm = 1'b1;
      end
    end
    return r;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = step(ma, 8, 32, 3, fim, ok, fec);
      mb = step(mb, 1, 4, 1, fim, ok, fec);
    end
  end
  always @(negedge clk) begin
    chk("A.trava", int'(ia.trava_aberta), int'(ma.open_left > 0));
    chk("A.cfg", int'(ia.cfg_permitido), int'(ma.open_left > 0));
    chk("A.bloq", int'(ia.bloqueado), int'(ma.lock_left > 0));
    chk("A.alarme", int'(ia.alarme), int'(ma.alarm));
    chk("A.tent", int'(ia.tentativas), ma.fails);
    chk("A.tecla_lib", int'(ia.tecla_lib), int'(tecla & reset_n & (ma.lock_left == 0)));
    chk("B.trava", int'(ib.trava_aberta), int'(mb.open_left > 0));
    chk("B.bloq", int'(ib.bloqueado), int'(mb.lock_left > 0));
    chk("B.alarme", int'(ib.alarme), int'(mb.alarm));
    chk("B.tent", int'(ib.tentativas), mb.fails);
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic pulse(input logic k);
    fim = 1'b1;
    ok  = k;
    cyc(1);
    fim = 1'b0;
    ok  = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0;
    #17 reset_n = 1'b1;
    chk("rst.trava", int'(ia.trava_aberta), 0);
    chk("rst.cfg", int'(ia.cfg_permitido), 0);
    chk("rst.bloq", int'(ia.bloqueado), 0);
    chk("rst.alarme", int'(ia.alarme), 0);
    chk("rst.tent", int'(ia.tentativas), 0);
    pulse(1'b1);
    chk("open.trava", int'(ia.trava_aberta), 1);
    chk("open.cfg", int'(ia.cfg_permitido), 1);
    chk("open.tent", int'(ia.tentativas), 0);
    chk("B.open1", int'(ib.trava_aberta), 1);
    cyc(7);
    chk("open.last", int'(ia.trava_aberta), 1);
    chk("B.closed", int'(ib.trava_aberta), 0);
    cyc(1);
    chk("open.end", int'(ia.trava_aberta), 0);
    pulse(1'b0);
    chk("fail1.tent", int'(ia.tentativas), 1);
    chk("B.lock", int'(ib.bloqueado), 1);
    chk("B.alarme", int'(ib.alarme), 1);
    chk("B.tent", int'(ib.tentativas), 1);
    pulse(1'b0);
    chk("fail2.tent", int'(ia.tentativas), 2);
    chk("fail2.bloq", int'(ia.bloqueado), 0);
    pulse(1'b0);
    chk("fail3.bloq", int'(ia.bloqueado), 1);
    chk("fail3.alarme", int'(ia.alarme), 1);
    chk("fail3.tent", int'(ia.tentativas), 3);
    cyc(1);
    chk("alarme.once", int'(ia.alarme), 0);
    tecla = 1'b1;
    #1 chk("lock.tecla_lib", int'(ia.tecla_lib), 0);
    tecla = 1'b0;
    pulse(1'b1);
    chk("lock.ignore_ok", int'(ia.trava_aberta), 0);
    chk("lock.still", int'(ia.bloqueado), 1);
    cyc(29);
    chk("lock.last", int'(ia.bloqueado), 1);
    cyc(1);
    chk("lock.end", int'(ia.bloqueado), 0);
    chk("lock.end_tent", int'(ia.tentativas), 0);
    tecla = 1'b1;
    #1 chk("idle.tecla_lib", int'(ia.tecla_lib), 1);
    tecla = 1'b0;
    pulse(1'b0);
    pulse(1'b0);
    chk("two.tent", int'(ia.tentativas), 2);
    pulse(1'b1);
    chk("clear.tent", int'(ia.tentativas), 0);
    chk("clear.trava", int'(ia.trava_aberta), 1);
    cyc(8);
    pulse(1'b0);
    chk("again.tent", int'(ia.tentativas), 1);
    chk("again.bloq", int'(ia.bloqueado), 0);
    pulse(1'b1);
    pulse(1'b0);
    chk("open.fail_ignored", int'(ia.tentativas), 0);
    chk("open.still", int'(ia.trava_aberta), 1);
    cyc(1);
    fec = 1'b1;
    cyc(1);
    fec = 1'b0;
    chk("fechar.close", int'(ia.trava_aberta), 0);
    pulse(1'b1);
    cyc(4);
    pulse(1'b1);
    cyc(7);
    chk("reload.last", int'(ia.trava_aberta), 1);
    cyc(1);
    chk("reload.end", int'(ia.trava_aberta), 0);
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b0);
    chk("lock2.bloq", int'(ia.bloqueado), 1);
    cyc(5);
    #1 reset_n = 1'b0;
    #1;
    chk("async.bloq", int'(ia.bloqueado), 0);
    chk("async.tent", int'(ia.tentativas), 0);
    chk("async.alarme", int'(ia.alarme), 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/controle_bloqueio.md
# controle_bloqueio

Access supervisor placed after the DigiLock control unit. Consumes the end-of-comparison result, drives the lock actuator for a timed open window, counts consecutive failed attempts and enforces a timed lockout that masks keypad strobes to the control unit. Also gates password reconfiguration so it is permitted only while the lock is open.

## Interface
- T_ABERTO, 8: open-window length in clk cycles, ≥1.
- T_BLOQUEIO, 32: lockout length in clk cycles, ≥1.
- MAX_TENTATIVAS, 3: consecutive failures that trigger lockout, 1..3.
- TW, 16: timer width; must hold max(T_ABERTO, T_BLOQUEIO)−1.

- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tecla_ativada  in  1  raw keypress strobe from keypad.
- verif_fim  in  1  one-cycle pulse: 4-digit comparison finished.
- verif_ok  in  1  comparison result, valid only when verif_fim=1 (1 = match).
- fechar  in  1  early-close request (door closed), level.
- tecla_lib  out  1  keypress strobe forwarded to control unit.
- trava_aberta  out  1  lock actuator, 1 = open.
- bloqueado  out  1  1 while in lockout.
- alarme  out  1  one-cycle pulse on lockout entry.
- cfg_permitido  out  1  password configuration allowed.
- tentativas  out  2  current consecutive-failure count.

## Operation
- States: OCIOSO, ABERTO, BLOQUEIO; encoding is an implementation choice. Single down-counter timer (TW bits), shared by ABERTO and BLOQUEIO.
- Reset (async, reset_n=0): state OCIOSO, timer 0, tentativas 0, trava_aberta 0, bloqueado 0, alarme 0, cfg_permitido 0.
- tecla_lib = tecla_ativada & reset_n & ~bloqueado (combinational, no added latency).
- trava_aberta, cfg_permitido = 1 exactly while state=ABERTO; bloqueado = 1 exactly while state=BLOQUEIO; all registered (state-decoded from flops).
- OCIOSO:
  - verif_fim & verif_ok → ABERTO, timer ← T_ABERTO−1, tentativas ← 0.
  - verif_fim & ~verif_ok, tentativas+1 < MAX_TENTATIVAS → stay, tentativas ← tentativas+1.
  - verif_fim & ~verif_ok, tentativas+1 = MAX_TENTATIVAS → BLOQUEIO, timer ← T_BLOQUEIO−1, tentativas ← MAX_TENTATIVAS, alarme=1 for the next cycle only.
- ABERTO:
  - fechar=1 → OCIOSO (highest priority).
  - else verif_fim & verif_ok → stay, timer reloaded to T_ABERTO−1.
  - else timer=0 → OCIOSO; else timer decrements.
  - verif_fim & ~verif_ok ignored, tentativas unchanged (stays 0).
- BLOQUEIO:
  - verif_fim, verif_ok, fechar ignored.
  - timer=0 → OCIOSO, tentativas ← 0; else timer decrements.
- tentativas never exceeds MAX_TENTATIVAS; no wrap.

## Timing
- verif_fim sampled at edge k → new state and outputs visible after edge k (one-cycle latency).
- ABERTO lasts exactly T_ABERTO cycles without fechar/reload; BLOQUEIO lasts exactly T_BLOQUEIO cycles.
- fechar sampled at edge k in ABERTO → trava_aberta=0 after edge k.
- alarme high for exactly the first cycle of BLOQUEIO.
- Reset mid-ABERTO or mid-BLOQUEIO: outputs drop immediately (asynchronous), failure history lost.
- verif_fim on the same edge as an ABERTO/BLOQUEIO timeout: timeout edge in BLOQUEIO ignores it; in ABERTO, success reload takes priority over timeout.
- verif_fim held >1 cycle is treated as one event per cycle (no edge detection).

## Test plan
- Reset, then verif_fim=1, verif_ok=1 at edge k → trava_aberta=1 and cfg_permitido=1 for cycles k..k+7, 0 after; tentativas=0.
- Three failures (verif_fim, verif_ok=0) → tentativas 1, 2; third → bloqueado=1, alarme pulse 1 cycle, tentativas=3; tecla_ativada=1 during lockout → tecla_lib=0; after 32 cycles bloqueado=0, tentativas=0.
- Two failures then success → tentativas cleared to 0 on open; next single failure → tentativas=1, no lockout.
- In ABERTO, fechar=1 at cycle 3 → trava_aberta=0 after that edge; success pulse at cycle 5 of a second window → window extended to 5+8 cycles.
- verif_fim & verif_ok during BLOQUEIO → ignored, trava_aberta stays 0; reset_n=0 mid-lockout → bloqueado=0 asynchronously, tentativas=0.
- With T_ABERTO=1, MAX_TENTATIVAS=1: success → one-cycle open pulse; single failure → immediate lockout with alarme.
